// File: rtl/param_counter.sv
// Parametrised up/down counter with prescaler, load, wrap modes and status flags.
// Optional capture register enabled by defining PARAM_COUNTER_CAPTURE_EN.
module param_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] presc,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  clr_flags,
`ifdef PARAM_COUNTER_CAPTURE_EN
    input  logic                  cap,
    output logic [WIDTH-1:0]      cap_val,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  wrapped,
    output logic                  done
);

    localparam logic [1:0] MODE_FREE = 2'd0;
    localparam logic [1:0] MODE_MOD  = 2'd1;
    localparam logic [1:0] MODE_ONE  = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    logic [PRESCALE_W-1:0] p;
    logic [PRESCALE_W-1:0] p_nxt;
    logic [WIDTH-1:0]      count_nxt;
    logic                  active;
    logic                  fire;
    logic                  term;
    logic                  step_ok;
    logic                  tc_nxt;
    logic                  done_nxt;

    always_comb begin
        active = en && (mode != MODE_HOLD);
        fire   = active && (p == presc);
        p_nxt  = p;
        if (active) begin
            p_nxt = fire ? '0 : p + 1'b1;
        end
    end

    always_comb begin
        unique case (mode)
            MODE_FREE: term = up ? (count == '1) : (count == '0);
            MODE_MOD,
            MODE_ONE:  term = up ? (count >= limit) : (count == '0);
            default:   term = 1'b0;
        endcase
    end

    // A finished one-shot swallows steps until reloaded.
    assign step_ok = fire && !((mode == MODE_ONE) && done);

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        done_nxt  = done;
        if (step_ok) begin
            if (term) begin
                tc_nxt = 1'b1;
                unique case (mode)
                    MODE_FREE: count_nxt = up ? '0 : '1;
                    MODE_MOD:  count_nxt = up ? '0 : limit;
                    MODE_ONE:  done_nxt  = 1'b1;
                    default:   count_nxt = count;
                endcase
            end else begin
                count_nxt = up ? count + 1'b1 : count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            p       <= '0;
            tc      <= 1'b0;
            wrapped <= 1'b0;
            done    <= 1'b0;
        end else if (load) begin
            count <= load_val;
            p     <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
            if (clr_flags) begin
                wrapped <= 1'b0;
            end
        end else begin
            count <= count_nxt;
            p     <= p_nxt;
            tc    <= tc_nxt;
            done  <= done_nxt;
            if (tc_nxt) begin
                wrapped <= 1'b1;
            end else if (clr_flags) begin
                wrapped <= 1'b0;
            end
        end
    end

`ifdef PARAM_COUNTER_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_val <= '0;
        end else if (cap) begin
            cap_val <= count;
        end
    end
`endif

endmodule

// File: tb/tb_param_counter.sv
// Randomised and directed check of param_counter against a behavioural model.
// Capture checks are included when PARAM_COUNTER_CAPTURE_EN is defined.
module tb_param_counter;

    localparam int W    = 8;
    localparam int PW   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          up = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [W-1:0]  limit = '0;
    logic [PW-1:0] presc = '0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic          clr_flags = 1'b0;
    logic [W-1:0]  count;
    logic          tc;
    logic          wrapped;
    logic          done;
`ifdef PARAM_COUNTER_CAPTURE_EN
    logic          cap = 1'b0;
    logic [W-1:0]  cap_val;
`endif

    int nvec = 0;
    int nerr = 0;

    int m_cnt = 0, m_p = 0, m_done = 0, m_wrap = 0, m_tc = 0, m_cap = 0;

    always #5 clk = ~clk;

    param_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .up(up),
        .mode(mode),
        .limit(limit),
        .presc(presc),
        .load(load),
        .load_val(load_val),
        .clr_flags(clr_flags),
`ifdef PARAM_COUNTER_CAPTURE_EN
        .cap(cap),
        .cap_val(cap_val),
`endif
        .count(count),
        .tc(tc),
        .wrapped(wrapped),
        .done(done)
    );

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the counter rules on integers each edge.
    always begin
        int old_cnt, step, term, ntc;
        @(posedge clk);
        old_cnt = m_cnt;
        if (rst) begin
            m_cnt = 0; m_p = 0; m_done = 0; m_wrap = 0; m_tc = 0; m_cap = 0;
        end else begin
`ifdef PARAM_COUNTER_CAPTURE_EN
            if (cap) m_cap = old_cnt;
`endif
            if (load) begin
                m_cnt = int'(load_val); m_p = 0; m_done = 0; m_tc = 0;
                if (clr_flags) m_wrap = 0;
            end else begin
                step = 0;
                if (en && mode != 2'd3) begin
                    if (m_p == int'(presc)) begin
                        step = 1; m_p = 0;
                    end else begin
                        m_p = (m_p + 1) % (1 << PW);
                    end
                end
                if (mode == 2'd0) term = up ? (m_cnt == MAXV) : (m_cnt == 0);
                else term = up ? (m_cnt >= int'(limit)) : (m_cnt == 0);
                ntc = 0;
                if (step && !(mode == 2'd2 && m_done)) begin
                    if (term) begin
                        ntc = 1;
                        if (mode == 2'd0) m_cnt = up ? 0 : MAXV;
                        else if (mode == 2'd1) m_cnt = up ? 0 : int'(limit);
                        else m_done = 1;
                    end else begin
                        m_cnt = (m_cnt + (up ? 1 : MAXV)) % (MAXV + 1);
                    end
                end
                m_tc = ntc;
                if (ntc) m_wrap = 1;
                else if (clr_flags) m_wrap = 0;
            end
        end
        #1;
        chk("count", int'(count), m_cnt);
        chk("tc", int'(tc), m_tc);
        chk("wrapped", int'(wrapped), m_wrap);
        chk("done", int'(done), m_done);
`ifdef PARAM_COUNTER_CAPTURE_EN
        chk("cap_val", int'(cap_val), m_cap);
`endif
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = W'(v);
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("rst_count", int'(count), 0);
        chk("rst_flags", int'({tc, wrapped, done}), 0);

        // free-run up from reset
        rst = 1'b0; en = 1'b1; up = 1'b1; mode = 2'd0; presc = '0;
        cyc(255);
        chk("free_255", int'(count), 255);
        chk("free_tc_pre", int'(tc), 0);
        cyc(1);
        chk("free_wrap_cnt", int'(count), 0);
        chk("free_wrap_tc", int'(tc), 1);
        chk("free_wrapped", int'(wrapped), 1);
        cyc(1);
        chk("free_tc_drop", int'(tc), 0);

        // modulo 5 with prescale 3
        clr_flags = 1'b1; cyc(1); clr_flags = 1'b0;
        mode = 2'd1; limit = 8'd5; presc = 4'd2;
        do_load(0);
        cyc(17);
        chk("mod_5", int'(count), 5);
        cyc(1);
        chk("mod_wrap", int'(count), 0);
        chk("mod_tc", int'(tc), 1);
        up = 1'b0;
        cyc(3);
        chk("mod_dn_lim", int'(count), 5);
        cyc(3);
        chk("mod_dn_4", int'(count), 4);

        // one-shot 250..252
        up = 1'b1; mode = 2'd2; limit = 8'd252; presc = '0;
        do_load(250);
        chk("os_load", int'(count), 250);
        cyc(2);
        chk("os_252", int'(count), 252);
        cyc(1);
        chk("os_done", int'({tc, done}), 3);
        cyc(3);
        chk("os_hold", int'({count, tc, done}), (252 << 2) | 1);
        do_load(0);
        chk("os_reload", int'(done), 0);
        cyc(1);
        chk("os_resume", int'(count), 1);

        // load beats a wrap step
        mode = 2'd0; clr_flags = 1'b1; cyc(1); clr_flags = 1'b0;
        do_load(255);
        load = 1'b1; load_val = 8'd9; clr_flags = 1'b1;
        cyc(1);
        load = 1'b0; clr_flags = 1'b0;
        chk("prio_load", int'({count, tc, wrapped}), 9 << 2);

        // reset beats load
        do_load(77);
        rst = 1'b1; load = 1'b1; load_val = 8'd33;
        cyc(1);
        rst = 1'b0; load = 1'b0;
        chk("prio_rst", int'({count, tc, wrapped, done}), 0);

        // freeze mid-prescale
        presc = 4'd3;
        do_load(10);
        cyc(1);
        en = 1'b0; cyc(5);
        en = 1'b1; mode = 2'd3; cyc(5);
        chk("freeze", int'({count, tc}), 10 << 1);
        mode = 2'd0;
        cyc(2);
        chk("resume_wait", int'(count), 10);
        cyc(1);
        chk("resume_step", int'(count), 11);

`ifdef PARAM_COUNTER_CAPTURE_EN
        presc = '0;
        do_load(40);
        cyc(2);
        cap = 1'b1; cyc(1); cap = 1'b0;
        chk("cap_42", int'(cap_val), 42);
        cyc(5);
        chk("cap_hold", int'(cap_val), 42);
`endif

        // randomised traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            load      = ($urandom_range(0, 15) == 0);
            clr_flags = !load && ($urandom_range(0, 15) == 0);
            en        = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) up = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) limit = W'($urandom);
            if ($urandom_range(0, 49) == 0) presc = PW'($urandom_range(0, 3));
            load_val = ($urandom_range(0, 3) == 0) ? W'(MAXV - $urandom_range(0, 2))
                                                   : W'($urandom);
`ifdef PARAM_COUNTER_CAPTURE_EN
            cap = ($urandom_range(0, 7) == 0);
`endif
            cyc(1);
        end
        rst = 1'b0; load = 1'b0; clr_flags = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
